// File: rtl/instr_encoder.sv
// Assembles 32-bit instruction words from operation requests, expanding LI into one or two words.
// Define ENCODER_STD_OPCODES_EN to use standard RV32I opcodes for BNE and JALR.
module instr_encoder #(
    parameter int ILLEGAL_NOP = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        instr_last,
    output logic        err_illegal
);

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
`ifdef ENCODER_STD_OPCODES_EN
    localparam logic [6:0] OP_BNE   = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
`else
    localparam logic [6:0] OP_BNE   = 7'b1001011;
    localparam logic [6:0] OP_JALR  = 7'b1001111;
`endif
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EMIT  = 2'd1;
    localparam logic [1:0] S_EMIT2 = 2'd2;

    logic [1:0]  state;
    logic        pend;
    logic [31:0] word2;
    logic [31:0] enc_w1;
    logic [31:0] enc_w2;
    logic        enc_long;
    logic        enc_legal;
    logic [19:0] li_hi;
    logic        busy;
    logic        accept;
    logic        emit_new;

    always_comb begin
        enc_w1    = '0;
        enc_w2    = '0;
        enc_long  = 1'b0;
        enc_legal = 1'b1;
        // Rounding the upper part compensates for addi sign-extending imm[11:0].
        li_hi     = req_imm[31:12] + {19'd0, req_imm[11]};
        case (req_op)
            4'd0: enc_w1 = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, OP_RTYPE};
            4'd1: enc_w1 = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_ITYPE};
            4'd2: enc_w1 = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
            4'd3: enc_w1 = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_STORE};
            4'd4: enc_w1 = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                            req_imm[4:1], req_imm[11], OP_BNE};
            4'd5: enc_w1 = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
            4'd6: enc_w1 = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
            4'd7: enc_w1 = {req_imm[31:12], req_rd, OP_AUIPC};
            4'd8: enc_w1 = {req_imm[31:12], req_rd, OP_LUI};
            4'd9: begin
                if ((&req_imm[31:11]) || !(|req_imm[31:11])) begin
                    enc_w1 = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_ITYPE};
                end else begin
                    enc_long = 1'b1;
                    enc_w1   = {li_hi, req_rd, OP_LUI};
                    enc_w2   = {req_imm[11:0], req_rd, 3'b000, req_rd, OP_ITYPE};
                end
            end
            default: begin
                enc_legal = 1'b0;
                enc_w1    = NOP_WORD;
            end
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign instr_valid = busy;
    assign req_ready   = !busy || (instr_ready && !pend);
    assign accept      = req_valid && req_ready;
    assign emit_new    = enc_legal || (ILLEGAL_NOP != 0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            instr       <= '0;
            instr_last  <= 1'b0;
            pend        <= 1'b0;
            word2       <= '0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= accept && !enc_legal;
            if (busy && instr_ready && pend) begin
                state      <= S_EMIT2;
                instr      <= word2;
                instr_last <= 1'b1;
                pend       <= 1'b0;
            end else if (accept && emit_new) begin
                state      <= S_EMIT;
                instr      <= enc_w1;
                instr_last <= !enc_long;
                pend       <= enc_long;
                word2      <= enc_w2;
            end else if (busy && instr_ready) begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: two instances (illegal -> nothing / illegal -> NOP) against a queue model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rv [2];
    logic        rr [2];
    logic [3:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ir;
    logic        iv [2];
    logic [31:0] iw [2];
    logic        il [2];
    logic        ei [2];

    always #5 clk = ~clk;

    instr_encoder #(.ILLEGAL_NOP(0)) u_enc0 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rr[0]), .req_op(op),
        .req_funct3(f3), .req_funct7(f7), .req_rd(rd), .req_rs1(rs1), .req_rs2(rs2),
        .req_imm(imm), .instr_valid(iv[0]), .instr_ready(ir), .instr(iw[0]),
        .instr_last(il[0]), .err_illegal(ei[0])
    );

    instr_encoder #(.ILLEGAL_NOP(1)) u_enc1 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rr[1]), .req_op(op),
        .req_funct3(f3), .req_funct7(f7), .req_rd(rd), .req_rs1(rs1), .req_rs2(rs2),
        .req_imm(imm), .instr_valid(iv[1]), .instr_ready(ir), .instr(iw[1]),
        .instr_last(il[1]), .err_illegal(ei[1])
    );

    typedef struct packed {
        logic [31:0] w;
        logic        last;
    } exp_t;

`ifdef ENCODER_STD_OPCODES_EN
    localparam int unsigned OPC_BNE  = 32'h63;
    localparam int unsigned OPC_JALR = 32'h67;
`else
    localparam int unsigned OPC_BNE  = 32'h4B;
    localparam int unsigned OPC_JALR = 32'h4F;
`endif

    exp_t q [2][$];
    logic exp_err [2];
    int   tests = 0;
    int   fails = 0;
    int   rdy_pct = 100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: instruction words built arithmetically from field values.
    task automatic model(input int d, output logic ill);
        int unsigned i, o, a3, a7, ad, a1, a2, hi, w;
        int s;
        i = imm; o = op; a3 = f3; a7 = f7; ad = rd; a1 = rs1; a2 = rs2;
        s = int'(imm);
        ill = 1'b0;
        w = 0;
        case (o)
            0: w = a7 * (1 << 25) + a2 * (1 << 20) + a1 * (1 << 15) + a3 * (1 << 12) + ad * 128 + 'h33;
            1: w = (i % 4096) * (1 << 20) + a1 * (1 << 15) + a3 * (1 << 12) + ad * 128 + 'h13;
            2: w = (i % 4096) * (1 << 20) + a1 * (1 << 15) + a3 * (1 << 12) + ad * 128 + 'h03;
            3: w = ((i / 32) % 128) * (1 << 25) + a2 * (1 << 20) + a1 * (1 << 15) + a3 * (1 << 12)
                   + (i % 32) * 128 + 'h23;
            4: w = ((i / 4096) % 2) * (1 << 31) + ((i / 32) % 64) * (1 << 25) + a2 * (1 << 20)
                   + a1 * (1 << 15) + a3 * (1 << 12) + ((i / 2) % 16) * 256 + ((i / 2048) % 2) * 128 + OPC_BNE;
            5: w = (i % 4096) * (1 << 20) + a1 * (1 << 15) + ad * 128 + OPC_JALR;
            6: w = ((i / (1 << 20)) % 2) * (1 << 31) + ((i / 2) % 1024) * (1 << 21)
                   + ((i / 2048) % 2) * (1 << 20) + ((i / 4096) % 256) * 4096 + ad * 128 + 'h6F;
            7: w = (i / 4096) * 4096 + ad * 128 + 'h17;
            8: w = (i / 4096) * 4096 + ad * 128 + 'h37;
            9: ;
            default: ill = 1'b1;
        endcase
        if (o == 9) begin
            if (s >= -2048 && s <= 2047) begin
                q[d].push_back('{w: (i % 4096) * (1 << 20) + ad * 128 + 'h13, last: 1'b1});
            end else begin
                hi = ((i + 'h800) / 4096) % (1 << 20);
                q[d].push_back('{w: hi * 4096 + ad * 128 + 'h37, last: 1'b0});
                q[d].push_back('{w: (i % 4096) * (1 << 20) + ad * (1 << 15) + ad * 128 + 'h13, last: 1'b1});
            end
        end else if (!ill) begin
            q[d].push_back('{w: w, last: 1'b1});
        end else if (d == 1) begin
            q[d].push_back('{w: 32'h13, last: 1'b1});
        end
    endtask

    // Evaluate one cycle: compare outputs, then apply this cycle's handshakes to the model.
    task automatic step();
        logic acc [2];
        logic ill;
        #1;
        for (int d = 0; d < 2; d++) begin
            acc[d] = 1'b0;
            check($sformatf("valid%0d", d), iv[d], q[d].size() != 0);
            if (q[d].size() != 0) begin
                check($sformatf("instr%0d", d), iw[d], q[d][0].w);
                check($sformatf("last%0d", d), il[d], q[d][0].last);
            end
            check($sformatf("err%0d", d), ei[d], exp_err[d]);
            check($sformatf("req_ready%0d", d), rr[d],
                  q[d].size() == 0 || (ir && q[d].size() == 1));
            if (q[d].size() != 0 && ir) void'(q[d].pop_front());
            exp_err[d] = 1'b0;
            if (rv[d] && rr[d]) begin
                model(d, ill);
                exp_err[d] = ill;
                acc[d] = 1'b1;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) if (acc[d]) rv[d] = 1'b0;
    endtask

    task automatic send(input logic [3:0] o, input logic [2:0] a3, input logic [6:0] a7,
                        input logic [4:0] ad, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] im);
        int n;
        op = o; f3 = a3; f7 = a7; rd = ad; rs1 = a1; rs2 = a2; imm = im;
        rv[0] = 1'b1; rv[1] = 1'b1;
        n = 0;
        while ((rv[0] || rv[1]) && n < 50) begin
            ir = ($urandom_range(99) < rdy_pct);
            step();
            n++;
        end
        check("accept_timeout", rv[0] | rv[1], 1'b0);
        rv[0] = 1'b0; rv[1] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            ir = ($urandom_range(99) < rdy_pct);
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        rv[0] = 1'b0; rv[1] = 1'b0; ir = 1'b1;
        op = '0; f3 = '0; f7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        exp_err[0] = 1'b0; exp_err[1] = 1'b0;
        reset = 1'b1;
        #3;
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", iv[d], 1'b0);
            check("rst_instr", iw[d], 32'h0);
            check("rst_last", il[d], 1'b0);
            check("rst_err", ei[d], 1'b0);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Directed: back-to-back RTYPE and ITYPE, long LI with stalled consumer, short LI, BNE
        rdy_pct = 100;
        send(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0);
        check("rtype_word", iw[0], 32'h002081B3);
        send(4'd1, 3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 32'h0FF);
        check("itype_word", iw[0], 32'h0FF06293);
        idle(2);
        rdy_pct = 0;
        send(4'd9, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
        idle(3);
        check("li_hi_word", iw[0], 32'h12346537);
        rdy_pct = 100;
        idle(1);
        check("li_lo_word", iw[0], 32'hFFF50513);
        send(4'd9, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFB);
        check("li_short_word", iw[0], 32'hFFB00093);
        send(4'd4, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 32'h8);
        send(4'd15, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        idle(3);

        // Reset while the second LI word is pending
        rdy_pct = 0;
        send(4'd9, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h80000000);
        idle(1);
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("midrst_valid", iv[d], 1'b0);
            check("midrst_instr", iw[d], 32'h0);
            check("midrst_last", il[d], 1'b0);
            q[d].delete();
            exp_err[d] = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
        rdy_pct = 100;
        send(4'd8, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'hABCDE123);
        idle(1);

        // Random requests with varying consumer back-pressure
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(2))
                0: rdy_pct = 100;
                1: rdy_pct = 70;
                default: rdy_pct = 30;
            endcase
            r = $urandom;
            if ($urandom_range(1) == 0) r = {{21{r[11]}}, r[10:0]};
            send(4'($urandom_range(15)), 3'($urandom), 7'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), r);
            if ($urandom_range(3) == 0) idle($urandom_range(3));
        end
        rdy_pct = 100;
        idle(4);
        check("drained0", q[0].size(), 0);
        check("drained1", q[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the control decoder. Takes a high-level operation request (op class, funct3/funct7, register indices, immediate) and assembles the 32-bit instruction word that the decoder consumes.
- Expands the LI pseudo-op into one or two words. Words are issued over a valid/ready stream.
- Used as the instruction source for pipeline benches and for instruction-memory preload.

Parameters:
- ILLEGAL_NOP, 0: when 1, an illegal op emits NOP 0x00000013; when 0, nothing is emitted.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_op  in  4  0 RTYPE, 1 ITYPE-ALU, 2 LOAD, 3 STORE, 4 BNE, 5 JALR, 6 JAL, 7 AUIPC, 8 LUI, 9 LI; 10-15 illegal
- req_funct3  in  3  funct3 field (RTYPE/ITYPE/LOAD/STORE/BNE)
- req_funct7  in  7  funct7 field (RTYPE only)
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  32  immediate; bit 0 ignored for BNE and JAL
- instr_valid  out  1  instr is valid
- instr_ready  in  1  consumer accepts instr
- instr  out  32  encoded word
- instr_last  out  1  final word of the current request
- err_illegal  out  1  one-cycle pulse on acceptance of an illegal op

Behaviour:
- Opcodes: RTYPE 0110011, ITYPE 0010011, LOAD 0000011, STORE 0100011, BNE 1001011, JALR 1001111, JAL 1101111, AUIPC 0010111, LUI 0110111.
- Formats:
  - R: funct7|rs2|rs1|f3|rd|op
  - I (ITYPE/LOAD/JALR): imm[11:0]|rs1|f3|rd|op; JALR forces f3=000
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
  - U (LUI/AUIPC): imm[31:12]|rd|op
- Fields not used by a format are ignored.
- LI, short form: if imm[31:11] are all equal, emit a single word, addi rd,x0,imm[11:0].
- LI, long form: otherwise emit two words.
  - Word 1: lui rd,(imm[31:12]+imm[11]) mod 2^20.
  - Word 2: addi rd,rd,imm[11:0].
- FSM states:
  - IDLE: no word held. req_ready=1.
  - EMIT: word held, instr_valid=1. On instr_ready: if an LI second word is pending, go to EMIT2; otherwise return to IDLE, or stay in EMIT if a new request is accepted in the same cycle.
  - EMIT2: second LI word held. On instr_ready, same exits as EMIT with no pending word.
- req_ready = IDLE | ((EMIT|EMIT2) & instr_ready & no pending second word). This gives back-to-back throughput of one word per cycle.
- Latency: word registered on the accept edge; instr_valid is high the next cycle.
- Hold rule: instr, instr_last and instr_valid are stable while instr_valid & !instr_ready.
- instr_last: 0 on word 1 of a long LI; 1 on every other word.
- Illegal op:
  - Always accepted; err_illegal pulses for exactly one cycle.
  - ILLEGAL_NOP=0: FSM stays in or returns to IDLE and no word is emitted.
  - ILLEGAL_NOP=1: emits 0x00000013 with instr_last=1.
- Reset values, asynchronous, including mid-operation: state IDLE, instr_valid 0, instr 0, instr_last 0, err_illegal 0. Any pending second word is discarded.

Optional Feature:
- Macro: ENCODER_STD_OPCODES_EN.
- Defined: BNE uses 1100011 and JALR uses 1100111 (standard RV32I).
- Undefined: 1001011 and 1001111 as listed above. All other opcodes are unaffected.

Test Plan:
- RTYPE f3=0 f7=0 rd=3 rs1=1 rs2=2, instr_ready=1 -> next cycle instr=0x002081B3, instr_last=1, req_ready stays 1.
- ITYPE f3=6 rd=5 rs1=0 imm=0x0FF, issued back-to-back after the previous request -> instr=0x0FF06293 on the following cycle, with no bubble.
- LI rd=10 imm=0x12345FFF, instr_ready held low 3 cycles -> instr=0x12346537 (last=0) held stable for 3 cycles; then 0xFFF50513 (last=1); req_ready=0 until the second word is accepted.
- LI rd=1 imm=0xFFFFFFFB -> single word 0xFFB00093, last=1.
- BNE f3=1 rs1=1 rs2=2 imm=8 -> 0x0020944B; with ENCODER_STD_OPCODES_EN -> 0x00209463.
- op=15 with ILLEGAL_NOP=0 -> err_illegal high 1 cycle, no instr_valid; ILLEGAL_NOP=1 -> instr=0x00000013. Reset asserted while the LI second word is pending -> instr_valid=0 immediately, next request encodes normally.
